// File: rtl/mdu_if.sv
// Command/result bundle between the E-stage issue logic and the multiply/divide controller.
interface mdu_if;
  logic        md_start;
  logic [3:0]  md_op;
  logic        md_rd_sel;
  logic        req;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] md_out;

  modport master (
    output md_start, md_op, md_rd_sel, req, A, B,
    input  busy, HI, LO, md_out
  );

  modport slave (
    input  md_start, md_op, md_rd_sel, req, A, B,
    output busy, HI, LO, md_out
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: fixed-latency mult/div sequencing, HI/LO ownership, mfhi/mflo read port.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are enabled by defining MDU_MACC_EN.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic rst_n,
  mdu_if.slave bus
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MACC_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif
  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  function automatic logic is_mc(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_mc = 1'b1;
`ifdef MDU_MACC_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mc = 1'b1;
`endif
      default: is_mc = 1'b0;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        mul_sgn_s, div_sgn_s, a_neg_s, b_neg_s;
  logic [63:0] a_ext_s, b_ext_s, prod_s;
  logic [31:0] ua_s, ub_s, uq_s, ur_s, q_s, r_s;
  logic [31:0] hi_nxt, lo_nxt;

  // Arithmetic on the latched operands; division works on magnitudes so the
  // 0x80000000 / -1 corner falls out naturally without overflow.
  always_comb begin
    mul_sgn_s = (op_q == OP_MULT);
`ifdef MDU_MACC_EN
    mul_sgn_s = mul_sgn_s | (op_q == OP_MADD) | (op_q == OP_MSUB);
`endif
    div_sgn_s = (op_q == OP_DIV);
    a_ext_s   = mul_sgn_s ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    b_ext_s   = mul_sgn_s ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    prod_s    = a_ext_s * b_ext_s;
    a_neg_s   = div_sgn_s & a_q[31];
    b_neg_s   = div_sgn_s & b_q[31];
    ua_s      = a_neg_s ? (32'd0 - a_q) : a_q;
    ub_s      = b_neg_s ? (32'd0 - b_q) : b_q;
    if (ub_s == 32'd0) begin
      uq_s = 32'd0;
      ur_s = 32'd0;
    end else begin
      uq_s = ua_s / ub_s;
      ur_s = ua_s % ub_s;
    end
    q_s = (a_neg_s ^ b_neg_s) ? (32'd0 - uq_s) : uq_s;
    r_s = a_neg_s ? (32'd0 - ur_s) : ur_s;
  end

  // Result that will be committed to HI/LO on the final RUN cycle.
  always_comb begin
    hi_nxt = hi_q;
    lo_nxt = lo_q;
    case (op_q)
      OP_MULT, OP_MULTU: {hi_nxt, lo_nxt} = prod_s;
      OP_DIV, OP_DIVU: begin
        if (b_q != 32'd0) begin
          hi_nxt = r_s;
          lo_nxt = q_s;
        end else begin
          hi_nxt = hi_q;
          lo_nxt = lo_q;
        end
      end
`ifdef MDU_MACC_EN
      OP_MADD, OP_MADDU: {hi_nxt, lo_nxt} = {hi_q, lo_q} + prod_s;
      OP_MSUB, OP_MSUBU: {hi_nxt, lo_nxt} = {hi_q, lo_q} - prod_s;
`endif
      default: begin
        hi_nxt = hi_q;
        lo_nxt = lo_q;
      end
    endcase
  end

  // Next-state: command acceptance in IDLE, countdown and commit in RUN.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          state_d = IDLE;
        end else if (bus.md_start && is_mc(bus.md_op)) begin
          state_d = RUN;
          busy_d  = 1'b1;
          cnt_d   = ((bus.md_op == OP_DIV) || (bus.md_op == OP_DIVU)) ? DIV_N : MULT_N;
          op_d    = bus.md_op;
          a_d     = bus.A;
          b_d     = bus.B;
        end else if (bus.md_op == OP_MTHI) begin
          hi_d = bus.A;
        end else if (bus.md_op == OP_MTLO) begin
          lo_d = bus.A;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = 4'd0;
          hi_d    = hi_nxt;
          lo_d    = lo_nxt;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.HI     = hi_q;
  assign bus.LO     = lo_q;
  assign bus.md_out = bus.md_rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized self-checking bench for mdu_ctrl against an arithmetic reference model.
module tb_mdu_ctrl;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_if u_if ();
  mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) u_dut (.clk(clk), .rst_n(rst_n), .bus(u_if.slave));

  always #5 clk = ~clk;

  // The hazard unit must never issue a new command while the unit is busy.
  always @(negedge clk) begin
    if (rst_n && u_if.md_start && u_if.busy) begin
      errors++;
      $display("FAIL start_while_busy: md_start=1 seen with busy=1");
    end
  end

  // Reference: HI/LO effect and busy length of one accepted command.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] eh, inout logic [31:0] el, output int n);
    logic [63:0] p, acc;
    longint sq, sr;
    n = 0;
    acc = {eh, el};
    p = 64'(longint'($signed(a)) * longint'($signed(b)));
    if (op == 4'd2 || op == 4'd8 || op == 4'd10) p = {32'd0, a} * {32'd0, b};
    case (op)
      4'd1, 4'd2: begin {eh, el} = p; n = MC; end
      4'd3: begin
        n = DC;
        if (b != 32'd0) begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          el = sq[31:0];
          eh = sr[31:0];
        end
      end
      4'd4: begin
        n = DC;
        if (b != 32'd0) begin el = a / b; eh = a % b; end
      end
      4'd5: eh = a;
      4'd6: el = a;
`ifdef MDU_MACC_EN
      4'd7, 4'd8: begin {eh, el} = acc + p; n = MC; end
      4'd9, 4'd10: begin {eh, el} = acc - p; n = MC; end
`endif
      default: n = 0;
    endcase
  endtask

  task automatic do_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic rq);
    logic [31:0] eh, el, sel_exp;
    int exp_n, n;
    logic held;
    @(negedge clk);
    u_if.md_start = ((op >= 4'd1 && op <= 4'd4) || (op >= 4'd7 && op <= 4'd10));
    u_if.md_op = op; u_if.A = a; u_if.B = b; u_if.req = rq;
    @(negedge clk);
    u_if.md_start = 1'b0; u_if.md_op = 4'd0; u_if.req = 1'b0;
    u_if.A = $urandom; u_if.B = $urandom;
    eh = m_hi; el = m_lo; exp_n = 0;
    if (!rq) model(op, a, b, eh, el, exp_n);
    n = 0; held = 1'b1;
    while (u_if.busy === 1'b1 && n < 40) begin
      if (u_if.HI !== m_hi || u_if.LO !== m_lo) held = 1'b0;
      n++;
      @(negedge clk);
    end
    tests++; if (n !== exp_n) begin errors++; $display("FAIL busy_len op=%0d: got %0d want %0d", op, n, exp_n); end
    tests++; if (held !== 1'b1) begin errors++; $display("FAIL hilo_held op=%0d: HI/LO changed while busy", op); end
    tests++; if (u_if.HI !== eh) begin errors++; $display("FAIL hi op=%0d a=%h b=%h: got %h want %h", op, a, b, u_if.HI, eh); end
    tests++; if (u_if.LO !== el) begin errors++; $display("FAIL lo op=%0d a=%h b=%h: got %h want %h", op, a, b, u_if.LO, el); end
    m_hi = eh; m_lo = el;
    u_if.md_rd_sel = 1'($urandom);
    sel_exp = u_if.md_rd_sel ? m_hi : m_lo;
    #1;
    tests++; if (u_if.md_out !== sel_exp) begin errors++; $display("FAIL md_out sel=%0d: got %h want %h", u_if.md_rd_sel, u_if.md_out, sel_exp); end
  endtask

  task automatic test_reset;
    #3;
    tests++; if (u_if.busy !== 1'b0 || u_if.HI !== 32'd0 || u_if.LO !== 32'd0)
      begin errors++; $display("FAIL reset: busy=%b HI=%h LO=%h want 0/0/0", u_if.busy, u_if.HI, u_if.LO); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mult_timing;
    do_cmd(4'd1, 32'hFFFFFFFF, 32'd2, 1'b0);
    tests++; if ({u_if.HI, u_if.LO} !== 64'hFFFFFFFF_FFFFFFFE)
      begin errors++; $display("FAIL mult_const: got %h%h want FFFFFFFFFFFFFFFE", u_if.HI, u_if.LO); end
    do_cmd(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
    tests++; if ({u_if.HI, u_if.LO} !== 64'h00000001_FFFFFFFE)
      begin errors++; $display("FAIL multu_const: got %h%h want 00000001FFFFFFFE", u_if.HI, u_if.LO); end
  endtask

  task automatic test_div;
    do_cmd(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    tests++; if ({u_if.HI, u_if.LO} !== 64'hFFFFFFFF_FFFFFFFD)
      begin errors++; $display("FAIL div_neg7: got %h%h want FFFFFFFFFFFFFFFD", u_if.HI, u_if.LO); end
    do_cmd(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    tests++; if ({u_if.HI, u_if.LO} !== 64'h00000000_80000000)
      begin errors++; $display("FAIL div_ovf: got %h%h want 0000000080000000", u_if.HI, u_if.LO); end
  endtask

  task automatic test_div_zero;
    do_cmd(4'd5, 32'h11, 32'd0, 1'b0);
    do_cmd(4'd6, 32'h22, 32'd0, 1'b0);
    do_cmd(4'd4, 32'd5, 32'd0, 1'b0);
    tests++; if (u_if.HI !== 32'h11 || u_if.LO !== 32'h22)
      begin errors++; $display("FAIL divzero: got %h/%h want 00000011/00000022", u_if.HI, u_if.LO); end
  endtask

  task automatic test_req_and_mt;
    logic [31:0] eh, el;
    int n;
    do_cmd(4'd1, 32'd3, 32'd4, 1'b1);
    // mtlo issued mid-operation must be dropped
    @(negedge clk);
    u_if.md_start = 1'b1; u_if.md_op = 4'd1; u_if.A = 32'd7; u_if.B = 32'd9;
    @(negedge clk);
    u_if.md_start = 1'b0; u_if.md_op = 4'd0;
    @(negedge clk);
    u_if.md_op = 4'd6; u_if.A = 32'h55;
    @(negedge clk);
    u_if.md_op = 4'd0;
    n = 0;
    while (u_if.busy === 1'b1 && n < 40) begin n++; @(negedge clk); end
    eh = m_hi; el = m_lo;
    model(4'd1, 32'd7, 32'd9, eh, el, n);
    m_hi = eh; m_lo = el;
    tests++; if (u_if.LO !== 32'd63 || u_if.HI !== 32'd0)
      begin errors++; $display("FAIL mtlo_busy: got %h/%h want 00000000/0000003f", u_if.HI, u_if.LO); end
    do_cmd(4'd6, 32'h55, 32'd0, 1'b0);
    u_if.md_rd_sel = 1'b0; #1;
    tests++; if (u_if.md_out !== 32'h55)
      begin errors++; $display("FAIL mtlo_idle: md_out got %h want 00000055", u_if.md_out); end
  endtask

  task automatic test_macc;
    do_cmd(4'd5, 32'd0, 32'd0, 1'b0);
    do_cmd(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0);
    do_cmd(4'd8, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MACC_EN
    tests++; if (u_if.HI !== 32'd1 || u_if.LO !== 32'd0)
      begin errors++; $display("FAIL maddu: got %h/%h want 00000001/00000000", u_if.HI, u_if.LO); end
`else
    tests++; if (u_if.HI !== 32'd0 || u_if.LO !== 32'hFFFFFFFF)
      begin errors++; $display("FAIL maddu_off: got %h/%h want 00000000/ffffffff", u_if.HI, u_if.LO); end
`endif
  endtask

  task automatic test_random;
    logic [3:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'h80000000;
      if ($urandom_range(0, 3) == 0) b = 32'hFFFFFFFF;
      do_cmd(op, a, b, ($urandom_range(0, 7) == 0));
    end
  endtask

  task automatic test_reset_mid;
    do_cmd(4'd5, 32'hABCD, 32'd0, 1'b0);
    @(negedge clk);
    u_if.md_start = 1'b1; u_if.md_op = 4'd1; u_if.A = 32'd100; u_if.B = 32'd200;
    @(negedge clk);
    u_if.md_start = 1'b0; u_if.md_op = 4'd0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests++; if (u_if.busy !== 1'b0 || u_if.HI !== 32'd0 || u_if.LO !== 32'd0)
      begin errors++; $display("FAIL reset_mid: busy=%b HI=%h LO=%h want 0/0/0", u_if.busy, u_if.HI, u_if.LO); end
    @(negedge clk); rst_n = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (8) @(negedge clk);
    tests++; if (u_if.busy !== 1'b0 || u_if.HI !== 32'd0 || u_if.LO !== 32'd0)
      begin errors++; $display("FAIL reset_after: busy=%b HI=%h LO=%h want 0/0/0", u_if.busy, u_if.HI, u_if.LO); end
  endtask

  initial begin
    u_if.md_start = 1'b0; u_if.md_op = 4'd0; u_if.md_rd_sel = 1'b0;
    u_if.req = 1'b0; u_if.A = 32'd0; u_if.B = 32'd0;
    test_reset;
    test_mult_timing;
    test_div;
    test_div_zero;
    test_req_and_mt;
    test_macc;
    test_random;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
